// File: rtl/cass_sd_pkg.sv
// Shared types for the cassette SD port arbiter: FSM states, owner encoding,
// and the default LBA width.
package cass_sd_pkg;
  localparam int CASS_LBA_W = 32;

  typedef enum logic [1:0] {S_IDLE, S_REQ, S_XFER, S_DONE} arb_state_t;
  typedef enum logic {OWN_RD, OWN_WR} owner_t;
endpackage

// File: rtl/cass_sd_arbiter.sv
// Round-robin arbiter sharing the cassette SD block port between the read and write engines.
// Optional request-phase timeout is enabled with the CASS_ARB_TIMEOUT_EN macro.
module cass_sd_arbiter
  import cass_sd_pkg::*;
#(
  parameter int          LBA_W       = CASS_LBA_W,
  parameter int unsigned TIMEOUT_CYC = 24'hFFFFFF
) (
  input  logic             CLK,
  input  logic             RESET,
  input  logic             rd_req,
  input  logic [LBA_W-1:0] rd_lba,
  input  logic             wr_req,
  input  logic [LBA_W-1:0] wr_lba,
  output logic             rd_gnt,
  output logic             wr_gnt,
  output logic             rd_ack,
  output logic             wr_ack,
  output logic             rd_done,
  output logic             wr_done,
  output logic             rd_buff_wr,
  output logic             err,
  output logic [LBA_W-1:0] sd_lba,
  output logic             sd_rd,
  output logic             sd_wr,
  input  logic             sd_ack,
  input  logic             sd_buff_wr
);

  arb_state_t       state_q, state_d;
  owner_t           last_owner_q, last_owner_d;
  logic             rd_gnt_q, rd_gnt_d, wr_gnt_q, wr_gnt_d;
  logic             sd_rd_q, sd_rd_d, sd_wr_q, sd_wr_d;
  logic             rd_done_q, rd_done_d, wr_done_q, wr_done_d;
  logic [LBA_W-1:0] sd_lba_q, sd_lba_d;
  logic             pick_rd;
  logic             owner_req;
  logic             timeout_hit;

  assign owner_req = rd_gnt_q ? rd_req : wr_req;

`ifdef CASS_ARB_TIMEOUT_EN
  logic [23:0] to_cnt_q, to_cnt_d;
  logic        err_q;

  // Counter only advances in S_REQ, so every entry into S_REQ starts from zero.
  always_comb begin
    to_cnt_d    = (state_q == S_REQ) ? to_cnt_q + 24'd1 : 24'd0;
    timeout_hit = (to_cnt_q == 24'(TIMEOUT_CYC - 1));
  end

  always_ff @(posedge CLK) begin
    if (RESET) begin
      to_cnt_q <= '0;
      err_q    <= 1'b0;
    end else begin
      to_cnt_q <= to_cnt_d;
      err_q    <= (state_q == S_REQ) && !sd_ack && owner_req && timeout_hit;
    end
  end
`else
  assign timeout_hit = 1'b0;
`endif

  always_ff @(posedge CLK) begin
    if (RESET) begin
      state_q      <= S_IDLE;
      last_owner_q <= OWN_WR;
      rd_gnt_q     <= 1'b0;
      wr_gnt_q     <= 1'b0;
      sd_rd_q      <= 1'b0;
      sd_wr_q      <= 1'b0;
      rd_done_q    <= 1'b0;
      wr_done_q    <= 1'b0;
      sd_lba_q     <= '0;
    end else begin
      state_q      <= state_d;
      last_owner_q <= last_owner_d;
      rd_gnt_q     <= rd_gnt_d;
      wr_gnt_q     <= wr_gnt_d;
      sd_rd_q      <= sd_rd_d;
      sd_wr_q      <= sd_wr_d;
      rd_done_q    <= rd_done_d;
      wr_done_q    <= wr_done_d;
      sd_lba_q     <= sd_lba_d;
    end
  end

  always_comb begin
    state_d      = state_q;
    last_owner_d = last_owner_q;
    rd_gnt_d     = rd_gnt_q;
    wr_gnt_d     = wr_gnt_q;
    sd_rd_d      = sd_rd_q;
    sd_wr_d      = sd_wr_q;
    sd_lba_d     = sd_lba_q;
    rd_done_d    = 1'b0;
    wr_done_d    = 1'b0;
    pick_rd      = 1'b0;
    case (state_q)
      S_IDLE: begin
        // A lingering sd_ack (after reset or abort) blocks new grants.
        if (!sd_ack && (rd_req || wr_req)) begin
          pick_rd      = rd_req && (!wr_req || last_owner_q == OWN_WR);
          rd_gnt_d     = pick_rd;
          wr_gnt_d     = !pick_rd;
          sd_rd_d      = pick_rd;
          sd_wr_d      = !pick_rd;
          sd_lba_d     = pick_rd ? rd_lba : wr_lba;
          last_owner_d = pick_rd ? OWN_RD : OWN_WR;
          state_d      = S_REQ;
        end
      end
      S_REQ: begin
        if (sd_ack) begin
          sd_rd_d = 1'b0;
          sd_wr_d = 1'b0;
          state_d = S_XFER;
        end else if (!owner_req || timeout_hit) begin
          sd_rd_d  = 1'b0;
          sd_wr_d  = 1'b0;
          rd_gnt_d = 1'b0;
          wr_gnt_d = 1'b0;
          state_d  = S_IDLE;
        end
      end
      S_XFER: begin
        if (!sd_ack) begin
          rd_done_d = rd_gnt_q;
          wr_done_d = wr_gnt_q;
          state_d   = S_DONE;
        end
      end
      S_DONE: begin
        rd_gnt_d = 1'b0;
        wr_gnt_d = 1'b0;
        state_d  = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    rd_gnt     = rd_gnt_q;
    wr_gnt     = wr_gnt_q;
    rd_ack     = sd_ack & rd_gnt_q;
    wr_ack     = sd_ack & wr_gnt_q;
    rd_buff_wr = sd_buff_wr & rd_gnt_q;
    rd_done    = rd_done_q;
    wr_done    = wr_done_q;
    sd_lba     = sd_lba_q;
    sd_rd      = sd_rd_q;
    sd_wr      = sd_wr_q;
`ifdef CASS_ARB_TIMEOUT_EN
    err        = err_q;
`else
    err        = 1'b0;
`endif
  end

endmodule

// File: tb/tb_cass_sd_arbiter.sv
// Self-checking bench for cass_sd_arbiter: directed scenarios plus a randomized
// run against a transaction-level round-robin model with an SD responder.
module tb_cass_sd_arbiter;
  localparam int LBA_W = 32;

  logic             CLK = 1'b0;
  logic             RESET;
  logic             rd_req, wr_req, sd_ack, sd_buff_wr;
  logic [LBA_W-1:0] rd_lba, wr_lba;
  logic             rd_gnt, wr_gnt, rd_ack, wr_ack, rd_done, wr_done, rd_buff_wr, err;
  logic [LBA_W-1:0] sd_lba;
  logic             sd_rd, sd_wr;

  int errors = 0;
  int checks = 0;

  always #5 CLK = ~CLK;

  cass_sd_arbiter #(.LBA_W(LBA_W), .TIMEOUT_CYC(16)) dut (
    .CLK(CLK), .RESET(RESET),
    .rd_req(rd_req), .rd_lba(rd_lba), .wr_req(wr_req), .wr_lba(wr_lba),
    .rd_gnt(rd_gnt), .wr_gnt(wr_gnt), .rd_ack(rd_ack), .wr_ack(wr_ack),
    .rd_done(rd_done), .wr_done(wr_done), .rd_buff_wr(rd_buff_wr), .err(err),
    .sd_lba(sd_lba), .sd_rd(sd_rd), .sd_wr(sd_wr),
    .sd_ack(sd_ack), .sd_buff_wr(sd_buff_wr)
  );

  task automatic step(input int n = 1);
    repeat (n) begin
      @(posedge CLK);
      #1;
    end
  endtask

  task automatic do_reset();
    RESET = 1'b1;
    rd_req = 0; wr_req = 0; sd_ack = 0; sd_buff_wr = 0; rd_lba = '0; wr_lba = '0;
    step(2);
    RESET = 1'b0;
  endtask

  task automatic test_reset();
    logic [9:0] outs;
    do_reset();
    outs = {rd_gnt, wr_gnt, rd_ack, wr_ack, rd_done, wr_done, rd_buff_wr, err, sd_rd, sd_wr};
    checks++;
    if (outs !== 10'b0) begin errors++; $display("FAIL reset_outs got=%b want=0", outs); end
    checks++;
    if (sd_lba !== '0) begin errors++; $display("FAIL reset_lba got=%0h want=0", sd_lba); end
    step();
    checks++;
    if ({rd_gnt, wr_gnt, sd_rd, sd_wr} !== 4'b0) begin
      errors++; $display("FAIL reset_idle got=%b want=0000", {rd_gnt, wr_gnt, sd_rd, sd_wr});
    end
  endtask

  task automatic test_single_read();
    logic bad;
    do_reset();
    rd_lba = 5; rd_req = 1;
    step();
    checks++;
    if ({rd_gnt, sd_rd, wr_gnt, sd_wr} !== 4'b1100) begin
      errors++; $display("FAIL rd_grant got=%b want=1100", {rd_gnt, sd_rd, wr_gnt, sd_wr});
    end
    checks++;
    if (sd_lba !== 5) begin errors++; $display("FAIL rd_lba got=%0h want=5", sd_lba); end
    bad = 0;
    repeat (2) begin step(); if (sd_rd !== 1'b1) bad = 1; end
    checks++;
    if (bad !== 1'b0) begin errors++; $display("FAIL rd_strobe_hold got=dropped want=held"); end
    sd_ack = 1;
    step();
    checks++;
    if ({sd_rd, rd_ack, rd_gnt, wr_ack} !== 4'b0110) begin
      errors++; $display("FAIL rd_ack_phase got=%b want=0110", {sd_rd, rd_ack, rd_gnt, wr_ack});
    end
    bad = 0;
    repeat (20) begin
      step();
      if (rd_done || wr_done || wr_gnt || wr_ack || sd_wr || sd_rd || !rd_ack) bad = 1;
    end
    checks++;
    if (bad !== 1'b0) begin errors++; $display("FAIL rd_xfer_quiet got=activity want=quiet"); end
    sd_ack = 0;
    step();
    checks++;
    if ({rd_done, wr_done} !== 2'b10) begin
      errors++; $display("FAIL rd_done got=%b want=10", {rd_done, wr_done});
    end
    rd_req = 0;
    step();
    checks++;
    if ({rd_done, rd_gnt} !== 2'b00) begin
      errors++; $display("FAIL rd_done_pulse got=%b want=00", {rd_done, rd_gnt});
    end
    checks++;
    if (sd_lba !== 5) begin errors++; $display("FAIL rd_lba_hold got=%0h want=5", sd_lba); end
  endtask

  task automatic test_tie();
    do_reset();
    rd_lba = 7; wr_lba = 9; rd_req = 1; wr_req = 1;
    step();
    checks++;
    if ({rd_gnt, wr_gnt, sd_rd, sd_wr} !== 4'b1010 || sd_lba !== 7) begin
      errors++; $display("FAIL tie1 got=%b lba=%0h want=1010 lba=7", {rd_gnt, wr_gnt, sd_rd, sd_wr}, sd_lba);
    end
    sd_ack = 1; step();
    sd_ack = 0; step();
    checks++;
    if (rd_done !== 1'b1) begin errors++; $display("FAIL tie1_done got=%b want=1", rd_done); end
    rd_req = 0;
    step();
    checks++;
    if ({rd_gnt, wr_gnt} !== 2'b00) begin
      errors++; $display("FAIL tie_gap got=%b want=00", {rd_gnt, wr_gnt});
    end
    step();
    checks++;
    if ({rd_gnt, wr_gnt, sd_rd, sd_wr} !== 4'b0101 || sd_lba !== 9) begin
      errors++; $display("FAIL tie2 got=%b lba=%0h want=0101 lba=9", {rd_gnt, wr_gnt, sd_rd, sd_wr}, sd_lba);
    end
    sd_ack = 1; step();
    sd_ack = 0; step();
    checks++;
    if ({wr_done, rd_done} !== 2'b10) begin
      errors++; $display("FAIL tie2_done got=%b want=10", {wr_done, rd_done});
    end
    wr_req = 0;
    step();
    rd_req = 1; wr_req = 1;
    step();
    checks++;
    if ({rd_gnt, wr_gnt} !== 2'b10 || sd_lba !== 7) begin
      errors++; $display("FAIL tie3 got=%b lba=%0h want=10 lba=7", {rd_gnt, wr_gnt}, sd_lba);
    end
    rd_req = 0; wr_req = 0;
    step(2);
  endtask

  task automatic test_buff_wr();
    logic bad;
    logic v;
    do_reset();
    wr_lba = 3; wr_req = 1;
    step();
    bad = 0;
    repeat (4) begin
      sd_buff_wr = ~sd_buff_wr; #1;
      if (rd_buff_wr !== 1'b0) bad = 1;
    end
    checks++;
    if (bad !== 1'b0) begin errors++; $display("FAIL buff_wr_writer got=leak want=0"); end
    wr_req = 0; sd_buff_wr = 0;
    step();
    rd_req = 1;
    step();
    bad = 0;
    repeat (4) begin
      v = 1'($urandom_range(0, 1));
      sd_buff_wr = v; #1;
      if (rd_buff_wr !== v) bad = 1;
    end
    checks++;
    if (bad !== 1'b0 || rd_gnt !== 1'b1) begin
      errors++; $display("FAIL buff_wr_reader got=mismatch gnt=%b want=mirror gnt=1", rd_gnt);
    end
    rd_req = 0; sd_buff_wr = 0;
    step(2);
  endtask

  task automatic test_cancel();
    logic bad;
    do_reset();
    wr_lba = 11; wr_req = 1;
    step();
    checks++;
    if (sd_wr !== 1'b1) begin errors++; $display("FAIL cancel_setup got=%b want=1", sd_wr); end
    wr_req = 0;
    step();
    checks++;
    if ({sd_wr, wr_gnt} !== 2'b00) begin
      errors++; $display("FAIL cancel_drop got=%b want=00", {sd_wr, wr_gnt});
    end
    bad = 0;
    repeat (3) begin step(); if (wr_done !== 1'b0) bad = 1; end
    checks++;
    if (bad !== 1'b0) begin errors++; $display("FAIL cancel_no_done got=pulse want=none"); end
    wr_req = 1;
    step();
    sd_ack = 1; step();
    wr_req = 0; step();
    checks++;
    if (wr_gnt !== 1'b1) begin errors++; $display("FAIL xfer_keep_gnt got=%b want=1", wr_gnt); end
    sd_ack = 0; step();
    checks++;
    if (wr_done !== 1'b1) begin errors++; $display("FAIL xfer_done got=%b want=1", wr_done); end
    step();
    checks++;
    if ({wr_done, wr_gnt} !== 2'b00) begin
      errors++; $display("FAIL xfer_end got=%b want=00", {wr_done, wr_gnt});
    end
  endtask

  task automatic test_reset_midxfer();
    logic bad;
    do_reset();
    rd_lba = 21; rd_req = 1;
    step();
    sd_ack = 1; step();
    RESET = 1; step(); RESET = 0;
    checks++;
    if ({rd_gnt, sd_rd, rd_ack, rd_done} !== 4'b0 || sd_lba !== '0) begin
      errors++; $display("FAIL midreset got=%b lba=%0h want=0000 lba=0", {rd_gnt, sd_rd, rd_ack, rd_done}, sd_lba);
    end
    bad = 0;
    repeat (3) begin step(); if (rd_gnt || sd_rd) bad = 1; end
    checks++;
    if (bad !== 1'b0) begin errors++; $display("FAIL stale_ack got=grant want=blocked"); end
    sd_ack = 0;
    step();
    checks++;
    if ({rd_gnt, sd_rd} !== 2'b11 || sd_lba !== 21) begin
      errors++; $display("FAIL regrant got=%b lba=%0h want=11 lba=15", {rd_gnt, sd_rd}, sd_lba);
    end
    rd_req = 0;
    step(2);
  endtask

  task automatic test_timeout();
    logic bad;
    do_reset();
    rd_lba = 1; rd_req = 1;
    step();
`ifdef CASS_ARB_TIMEOUT_EN
    bad = 0;
    for (int i = 1; i < 16; i++) begin
      step();
      if (err !== 1'b0 || rd_gnt !== 1'b1) bad = 1;
    end
    checks++;
    if (bad !== 1'b0) begin errors++; $display("FAIL timeout_early got=abort want=wait"); end
    step();
    checks++;
    if ({err, rd_gnt, sd_rd, rd_done} !== 4'b1000) begin
      errors++; $display("FAIL timeout_abort got=%b want=1000", {err, rd_gnt, sd_rd, rd_done});
    end
    step();
    checks++;
    if (err !== 1'b0) begin errors++; $display("FAIL timeout_pulse got=%b want=0", err); end
`else
    bad = 0;
    repeat (100) begin
      step();
      if (sd_rd !== 1'b1 || rd_gnt !== 1'b1 || err !== 1'b0) bad = 1;
    end
    checks++;
    if (bad !== 1'b0) begin errors++; $display("FAIL no_timeout got=abort want=wait"); end
`endif
    rd_req = 0;
    step(2);
  endtask

  task automatic test_random();
    int last_own, cur, phase, dly, len, exp_o, got_o, max_wait;
    int grants[2];
    int dones[2];
    int wait_c[2];
    logic p_rd, p_wr, p_ack;
    logic [LBA_W-1:0] lba[2];
    do_reset();
    last_own = 1; cur = -1; phase = 0; dly = 0; len = 0; max_wait = 0;
    grants = '{0, 0}; dones = '{0, 0}; wait_c = '{0, 0};
    p_rd = 0; p_wr = 0; p_ack = 0; lba = '{0, 0};
    for (int cyc = 0; cyc < 3300; cyc++) begin
      step();
      checks++;
      if ((rd_gnt && wr_gnt) || (sd_rd && sd_wr) || (sd_rd && !rd_gnt) || (sd_wr && !wr_gnt)) begin
        errors++; $display("FAIL rand_excl cyc=%0d got gnt=%b%b strb=%b%b want exclusive", cyc, rd_gnt, wr_gnt, sd_rd, sd_wr);
      end
      checks++;
      if (rd_ack !== (sd_ack & rd_gnt) || wr_ack !== (sd_ack & wr_gnt) || rd_buff_wr !== (sd_buff_wr & rd_gnt)) begin
        errors++; $display("FAIL rand_gate cyc=%0d got=%b%b%b want gated", cyc, rd_ack, wr_ack, rd_buff_wr);
      end
      if (cur < 0) begin
        if (rd_gnt || wr_gnt) begin
          exp_o = (p_rd && p_wr) ? 1 - last_own : (p_rd ? 0 : 1);
          got_o = rd_gnt ? 0 : 1;
          checks++;
          if (!(p_rd || p_wr) || p_ack || got_o != exp_o) begin
            errors++; $display("FAIL rand_owner cyc=%0d got=%0d want=%0d", cyc, got_o, exp_o);
          end
          checks++;
          if (sd_lba !== lba[got_o]) begin
            errors++; $display("FAIL rand_lba cyc=%0d got=%0h want=%0h", cyc, sd_lba, lba[got_o]);
          end
          checks++;
          if ({sd_rd, sd_wr} !== ((got_o == 0) ? 2'b10 : 2'b01)) begin
            errors++; $display("FAIL rand_strobe cyc=%0d got=%b%b", cyc, sd_rd, sd_wr);
          end
          cur = got_o; last_own = got_o; grants[got_o]++;
        end
      end else begin
        checks++;
        if ((cur == 0 && !rd_gnt) || (cur == 1 && !wr_gnt)) begin
          errors++; $display("FAIL rand_gnt_hold cyc=%0d got=%b%b owner=%0d", cyc, rd_gnt, wr_gnt, cur);
        end
      end
      if (rd_done || wr_done) begin
        checks++;
        if (cur < 0 || (rd_done && wr_done) || (rd_done && cur != 0) || (wr_done && cur != 1)) begin
          errors++; $display("FAIL rand_done cyc=%0d got=%b%b owner=%0d", cyc, rd_done, wr_done, cur);
        end else begin
          dones[cur]++;
          if (cur == 0) rd_req = 0; else wr_req = 0;
        end
        cur = -1;
      end
      // SD port responder: ack some cycles after a strobe, hold it for a burst
      if (phase == 2) begin
        len--;
        if (len == 0) begin sd_ack = 0; phase = 0; end
      end else if (phase == 1) begin
        if (dly == 0) begin sd_ack = 1; len = $urandom_range(1, 5); phase = 2; end
        else dly--;
      end else if (sd_rd || sd_wr) begin
        dly = $urandom_range(0, 3); phase = 1;
      end
      sd_buff_wr = 1'($urandom_range(0, 1));
      if (cyc < 3000) begin
        if (!rd_req && $urandom_range(0, 3) == 0) begin rd_req = 1; rd_lba = $urandom; lba[0] = rd_lba; end
        if (!wr_req && $urandom_range(0, 3) == 0) begin wr_req = 1; wr_lba = $urandom; lba[1] = wr_lba; end
      end
      wait_c[0] = (rd_req && cur != 0) ? wait_c[0] + 1 : 0;
      wait_c[1] = (wr_req && cur != 1) ? wait_c[1] + 1 : 0;
      if (wait_c[0] > max_wait) max_wait = wait_c[0];
      if (wait_c[1] > max_wait) max_wait = wait_c[1];
      p_rd = rd_req; p_wr = wr_req; p_ack = sd_ack;
    end
    checks++;
    if (max_wait > 60) begin errors++; $display("FAIL rand_starve got=%0d want<=60", max_wait); end
    checks++;
    if (grants[0] != dones[0] || grants[1] != dones[1]) begin
      errors++; $display("FAIL rand_complete got=%0d/%0d want=%0d/%0d", dones[0], dones[1], grants[0], grants[1]);
    end
    checks++;
    if (grants[0] < 10 || grants[1] < 10 || rd_req || wr_req) begin
      errors++; $display("FAIL rand_activity got=%0d/%0d pend=%b%b", grants[0], grants[1], rd_req, wr_req);
    end
  endtask

  initial begin
    RESET = 1;
    rd_req = 0; wr_req = 0; sd_ack = 0; sd_buff_wr = 0; rd_lba = '0; wr_lba = '0;
    test_reset();
    test_single_read();
    test_tie();
    test_buff_wr();
    test_cancel();
    test_reset_midxfer();
    test_timeout();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
